vlsu_axi_wr_limiter: RTL and testbench

Sits directly downstream of the vector load/store unit's AXI write path (AW/W/B), between the VLSU and the memory-side AXI cut. Caps the number of outstanding write bursts and guarantees that W beats never reach memory ahead of their AW. Exposes idle and protocol-error status to the dispatcher.

---
 rtl/vlsu_axi_wr_limiter.sv | 171 +++++++++++++++++
 tb/tb_vlsu_axi_wr_limiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_axi_wr_limiter.sv
// vlsu_axi_wr_limiter: caps outstanding AXI write bursts from the VLSU and holds
// W beats back until their AW has been accepted downstream. Tracks burst lengths
// in a small FIFO to check W.last placement and flags protocol errors (sticky).

package vlsu_axi_wr_limiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_t;
endpackage

module vlsu_axi_wr_limiter #(
    parameter int unsigned MaxOutstanding = 4,
    parameter type axi_aw_t = vlsu_axi_wr_limiter_pkg::aw_t,
    parameter type axi_w_t  = vlsu_axi_wr_limiter_pkg::w_t,
    parameter type axi_b_t  = vlsu_axi_wr_limiter_pkg::b_t
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  axi_aw_t slv_aw_i,
    input  logic    slv_aw_valid_i,
    output logic    slv_aw_ready_o,
    input  axi_w_t  slv_w_i,
    input  logic    slv_w_valid_i,
    output logic    slv_w_ready_o,
    output axi_b_t  slv_b_o,
    output logic    slv_b_valid_o,
    input  logic    slv_b_ready_i,
    output axi_aw_t mst_aw_o,
    output logic    mst_aw_valid_o,
    input  logic    mst_aw_ready_i,
    output axi_w_t  mst_w_o,
    output logic    mst_w_valid_o,
    input  logic    mst_w_ready_i,
    input  axi_b_t  mst_b_i,
    input  logic    mst_b_valid_i,
    output logic    mst_b_ready_o,
    output logic    idle_o,
    output logic    proto_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [CntW-1:0] outst_cnt_q, outst_cnt_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]      fifo_mem_q [MaxOutstanding];
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic            proto_err_q, proto_err_d;

    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic       aw_block, w_en;
    logic       aw_hs, w_hs, b_hs;
    logic       last_beat;
    logic       push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (fifo_cnt_q == MaxCnt);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // AW is blocked purely from registered state, so a same-cycle B or pop never frees a slot.
    assign aw_block = (outst_cnt_q == MaxCnt) | fifo_full;
    assign w_en     = ~fifo_empty;

    assign mst_aw_o       = slv_aw_i;
    assign mst_aw_valid_o = ~rst_i & slv_aw_valid_i & ~aw_block;
    assign slv_aw_ready_o = ~rst_i & mst_aw_ready_i & ~aw_block;

    assign mst_w_o        = slv_w_i;
    assign mst_w_valid_o  = ~rst_i & slv_w_valid_i & w_en;
    assign slv_w_ready_o  = ~rst_i & mst_w_ready_i & w_en;

    assign slv_b_o        = mst_b_i;
    assign slv_b_valid_o  = ~rst_i & mst_b_valid_i;
    assign mst_b_ready_o  = ~rst_i & slv_b_ready_i;

    assign aw_hs = slv_aw_valid_i & slv_aw_ready_o;
    assign w_hs  = slv_w_valid_i & slv_w_ready_o;
    assign b_hs  = slv_b_valid_o & mst_b_ready_o;

    assign last_beat = (beat_cnt_q == fifo_head);
    assign push      = aw_hs;
    assign pop       = w_hs & last_beat;

    assign idle_o      = (outst_cnt_q == '0) & fifo_empty;
    assign proto_err_o = proto_err_q;

    // Next-state for counters, FIFO pointers and the sticky error flag.
    always_comb begin
        outst_cnt_d = outst_cnt_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        proto_err_d = proto_err_q;

        if (aw_hs && !b_hs) begin
            outst_cnt_d = outst_cnt_q + 1'b1;
        end else if (b_hs && !aw_hs && (outst_cnt_q != '0)) begin
            outst_cnt_d = outst_cnt_q - 1'b1;
        end

        if (b_hs && (outst_cnt_q == '0)) begin
            proto_err_d = 1'b1;
        end

        if (w_hs) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
            if (slv_w_i.last != last_beat) begin
                proto_err_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_cnt_q <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            outst_cnt_q <= outst_cnt_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Burst-length storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= slv_aw_i.len;
        end
    end

endmodule

// File: tb/tb_vlsu_axi_wr_limiter.sv
// Self-checking bench for vlsu_axi_wr_limiter: a table of combinational
// handshake vectors plus directed multi-cycle sequences, with a W scoreboard.
module tb_vlsu_axi_wr_limiter;
    import vlsu_axi_wr_limiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    aw_t  slv_aw, mst_aw_o;
    logic slv_aw_valid, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready;
    w_t   slv_w, mst_w_o;
    logic slv_w_valid, slv_w_ready_o, mst_w_valid_o, mst_w_ready;
    b_t   mst_b, slv_b_o;
    logic mst_b_valid, slv_b_valid_o, slv_b_ready, mst_b_ready_o;
    logic idle_o, proto_err_o;

    int errors = 0;
    int checks = 0;
    int fwd_cnt = 0;
    w_t sb[$];

    vlsu_axi_wr_limiter #(
        .MaxOutstanding(4),
        .axi_aw_t(aw_t),
        .axi_w_t(w_t),
        .axi_b_t(b_t)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_i(slv_aw), .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready_o),
        .slv_w_i(slv_w), .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready_o),
        .slv_b_o(slv_b_o), .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready),
        .mst_aw_o(mst_aw_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready),
        .mst_w_o(mst_w_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready),
        .mst_b_i(mst_b), .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready_o),
        .idle_o(idle_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // W monitor: a handshake is pending whenever valid/ready are high mid-cycle.
    always @(negedge clk) begin
        if (!rst && mst_w_valid_o && mst_w_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w_unexpected: beat %h forwarded, none expected", mst_w_o);
            end else begin
                w_t e;
                e = sb.pop_front();
                chk("w_fwd_data", mst_w_o == e, 1'b1);
                fwd_cnt++;
            end
        end
    end

    task automatic clear_inputs();
        slv_aw = '0; slv_aw_valid = 0; mst_aw_ready = 0;
        slv_w = '0; slv_w_valid = 0; mst_w_ready = 0;
        mst_b = '0; mst_b_valid = 0; slv_b_ready = 0;
    endtask

    // All tasks below start and end at posedge+1.
    task automatic reset_dut();
        rst = 1;
        clear_inputs();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic do_aw(input logic [7:0] len, output int waited);
        bit hs, done;
        slv_aw.addr = $urandom;
        slv_aw.len = len;
        slv_aw_valid = 1;
        mst_aw_ready = 1;
        waited = 0;
        done = 0;
        while (!done) begin
            #3 hs = slv_aw_ready_o;
            if (hs) chk("aw_passthrough", mst_aw_o == slv_aw, 1'b1);
            @(posedge clk);
            #1;
            if (hs || waited > 50) done = 1;
            else waited++;
        end
        slv_aw_valid = 0;
    endtask

    task automatic do_w(input logic last, output int waited);
        bit hs, done;
        slv_w.data = $urandom;
        slv_w.last = last;
        slv_w_valid = 1;
        mst_w_ready = 1;
        sb.push_back(slv_w);
        waited = 0;
        done = 0;
        while (!done) begin
            #3 hs = slv_w_ready_o;
            @(posedge clk);
            #1;
            if (hs || waited > 50) done = 1;
            else waited++;
        end
        slv_w_valid = 0;
    endtask

    task automatic do_b();
        mst_b.resp = 2'($urandom);
        mst_b_valid = 1;
        slv_b_ready = 1;
        #3;
        chk("b_passthrough", slv_b_o == mst_b && slv_b_valid_o && mst_b_ready_o, 1'b1);
        @(posedge clk);
        #1;
        mst_b_valid = 0;
        slv_b_ready = 0;
    endtask

    typedef struct {
        logic       loaded;
        logic [5:0] in;   // {aw_v, mst_aw_r, w_v, mst_w_r, mst_b_v, slv_b_r}
        logic [5:0] exp;  // {mst_aw_v, slv_aw_r, mst_w_v, slv_w_r, slv_b_v, mst_b_r}
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w;
        bit hs;
        int base;
        bit tog;
        int beat;
        bit pushed;

        vecs[0] = '{1'b0, 6'b111111, 6'b110011};
        vecs[1] = '{1'b0, 6'b101010, 6'b100010};
        vecs[2] = '{1'b0, 6'b010101, 6'b010001};
        vecs[3] = '{1'b0, 6'b000000, 6'b000000};
        vecs[4] = '{1'b1, 6'b111111, 6'b111111};
        vecs[5] = '{1'b1, 6'b101010, 6'b101010};
        vecs[6] = '{1'b1, 6'b010101, 6'b010101};
        vecs[7] = '{1'b1, 6'b110000, 6'b110000};

        // Reset forces every valid/ready output low even with all inputs high.
        rst = 1;
        clear_inputs();
        {slv_aw_valid, mst_aw_ready, slv_w_valid, mst_w_ready, mst_b_valid, slv_b_ready} = '1;
        #1;
        chk_int("reset_outputs",
                {mst_aw_valid_o, slv_aw_ready_o, mst_w_valid_o, slv_w_ready_o, slv_b_valid_o, mst_b_ready_o}, 0);
        reset_dut();
        #3;
        chk("reset_idle", idle_o, 1'b1);
        chk("reset_err", proto_err_o, 1'b0);
        @(posedge clk); #1;

        // Table: combinational gating with FIFO empty, then with one AW accepted.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].loaded && idle_o) begin
                do_aw(8'd0, w);
                chk_int("table_setup_aw", w, 0);
            end
            @(posedge clk);
            #2;
            {slv_aw_valid, mst_aw_ready, slv_w_valid, mst_w_ready, mst_b_valid, slv_b_ready} = vecs[i].in;
            slv_aw = aw_t'({$urandom, $urandom});
            slv_w = w_t'({$urandom, $urandom});
            mst_b = b_t'($urandom);
            #1;
            chk_int($sformatf("table_vec%0d", i),
                    {mst_aw_valid_o, slv_aw_ready_o, mst_w_valid_o, slv_w_ready_o, slv_b_valid_o, mst_b_ready_o},
                    vecs[i].exp);
            chk($sformatf("table_data%0d", i),
                mst_aw_o == slv_aw && mst_w_o == slv_w && slv_b_o == mst_b, 1'b1);
            clear_inputs();
        end
        @(posedge clk); #1;

        // Single burst len=3: W held off in the AW cycle, then four beats back to back.
        reset_dut();
        slv_aw.len = 8'd3; slv_aw_valid = 1; mst_aw_ready = 1;
        slv_w.data = 32'h1234; slv_w_valid = 1; mst_w_ready = 1;
        #3;
        chk("sb_aw_ready", slv_aw_ready_o, 1'b1);
        chk("sb_w_blocked", mst_w_valid_o | slv_w_ready_o, 1'b0);
        @(posedge clk); #1;
        slv_aw_valid = 0;
        base = fwd_cnt;
        for (int i = 0; i < 4; i++) begin
            do_w(i == 3, w);
            chk_int("sb_beat_wait", w, 0);
        end
        chk_int("sb_fwd_count", fwd_cnt - base, 4);
        chk("sb_not_idle_before_b", idle_o, 1'b0);
        do_b();
        chk("sb_idle", idle_o, 1'b1);
        chk("sb_err", proto_err_o, 1'b0);

        // Outstanding cap: 4 AWs accepted, 5th waits until the cycle after a B.
        reset_dut();
        slv_aw.len = 8'd0; slv_aw_valid = 1; mst_aw_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #3 hs = slv_aw_ready_o;
            chk($sformatf("cap_aw%0d", i), hs, i < 4);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            do_w(1'b1, w);
            chk_int("cap_drain_wait", w, 0);
        end
        #3 chk("cap_blocked_by_count", slv_aw_ready_o, 1'b0);
        @(posedge clk); #1;
        mst_b_valid = 1; slv_b_ready = 1;
        #3 chk("cap_no_bypass", slv_aw_ready_o, 1'b0);
        @(posedge clk); #1;
        mst_b_valid = 0; slv_b_ready = 0;
        #3 chk("cap_accept_after_b", slv_aw_ready_o, 1'b1);
        @(posedge clk); #1;
        slv_aw_valid = 0;
        chk("cap_err", proto_err_o, 1'b0);

        // Coincident AW+B at two outstanding: counter holds, FIFO grows.
        reset_dut();
        do_aw(8'd0, w);
        do_aw(8'd0, w);
        slv_aw.len = 8'd0; slv_aw_valid = 1; mst_aw_ready = 1;
        mst_b_valid = 1; slv_b_ready = 1;
        #3 chk("co_both_hs", slv_aw_ready_o & slv_b_valid_o & mst_b_ready_o, 1'b1);
        @(posedge clk); #1;
        clear_inputs();
        do_aw(8'd0, w);
        chk_int("co_aw3_wait", w, 0);
        slv_aw_valid = 1; mst_aw_ready = 1;
        #3 chk("co_fifo_full", slv_aw_ready_o, 1'b0);
        @(posedge clk); #1;
        slv_aw_valid = 0;
        for (int i = 0; i < 4; i++) do_w(1'b1, w);
        do_aw(8'd0, w);
        chk_int("co_aw4_wait", w, 0);
        slv_aw_valid = 1;
        #3 chk("co_count_full", slv_aw_ready_o, 1'b0);
        @(posedge clk); #1;
        slv_aw_valid = 0;
        do_w(1'b1, w);
        for (int i = 0; i < 3; i++) do_b();
        chk("co_not_idle", idle_o, 1'b0);
        do_b();
        chk("co_idle", idle_o, 1'b1);
        chk("co_err", proto_err_o, 1'b0);

        // Early W.last on beat 2 of a len=3 burst sets the sticky error.
        reset_dut();
        do_aw(8'd3, w);
        do_w(1'b0, w);
        chk("pe_clean", proto_err_o, 1'b0);
        do_w(1'b1, w);
        chk("pe_early_last", proto_err_o, 1'b1);
        do_w(1'b0, w);
        do_w(1'b1, w);
        do_b();
        chk("pe_sticky", proto_err_o, 1'b1);
        chk("pe_idle", idle_o, 1'b1);
        reset_dut();
        #3 chk("pe_cleared", proto_err_o, 1'b0);
        @(posedge clk); #1;
        do_b();
        chk("pe_spurious_b", proto_err_o, 1'b1);
        chk("pe_cnt_stays0", idle_o, 1'b1);

        // Backpressure: W ready toggles 1010 across a len=7 burst.
        reset_dut();
        do_aw(8'd7, w);
        base = fwd_cnt;
        tog = 1;
        beat = 0;
        pushed = 0;
        for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
            if (!pushed) begin
                slv_w.data = 32'hA000 + beat;
                slv_w.last = (beat == 7);
                sb.push_back(slv_w);
                pushed = 1;
            end
            slv_w_valid = 1;
            mst_w_ready = tog;
            #3 hs = slv_w_ready_o;
            @(posedge clk); #1;
            tog = ~tog;
            if (hs) begin
                beat++;
                pushed = 0;
            end
        end
        slv_w_valid = 0; mst_w_ready = 0;
        chk_int("bp_beats_accepted", beat, 8);
        chk_int("bp_fwd_count", fwd_cnt - base, 8);
        chk("bp_err", proto_err_o, 1'b0);
        slv_w_valid = 1; mst_w_ready = 1;
        #3 chk("bp_fifo_empty", mst_w_valid_o, 1'b0);
        slv_w_valid = 0;
        @(posedge clk); #1;
        do_aw(8'd0, w);
        do_w(1'b1, w);
        chk("bp_beat_cnt_wrapped", proto_err_o, 1'b0);
        do_b();
        do_b();
        chk("bp_idle", idle_o, 1'b1);

        // Reset after 2 of 4 beats discards the burst.
        reset_dut();
        do_aw(8'd3, w);
        do_w(1'b0, w);
        do_w(1'b0, w);
        rst = 1;
        {slv_aw_valid, mst_aw_ready, slv_w_valid, mst_w_ready, mst_b_valid, slv_b_ready} = '1;
        #1;
        chk_int("mr_outputs_low",
                {mst_aw_valid_o, slv_aw_ready_o, mst_w_valid_o, slv_w_ready_o, slv_b_valid_o, mst_b_ready_o}, 0);
        @(posedge clk); #1;
        reset_dut();
        #3;
        chk("mr_idle", idle_o, 1'b1);
        chk("mr_err", proto_err_o, 1'b0);
        @(posedge clk); #1;
        do_aw(8'd0, w);
        chk_int("mr_new_aw_wait", w, 0);
        do_w(1'b1, w);
        chk_int("mr_new_w_wait", w, 0);
        do_b();
        chk("mr_final_idle", idle_o, 1'b1);
        chk("mr_final_err", proto_err_o, 1'b0);

        @(posedge clk); #1;
        chk_int("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
